// File: rtl/sm_imem_loader.sv
// sm_imem_loader
//   Byte-stream program loader for the schoolRISCV core. It parses frames of
//   the form A5, L, 4*L little-endian data bytes, and a checksum byte. The
//   checksum is the XOR of L and every data byte. Each assembled word is
//   written to instruction memory, starting at word address 0. The CPU is held
//   in reset from the header until the checksum is accepted and matches.
// Ports
//   clk, rst     : system clock; asynchronous active-high reset
//   rx_valid     : byte available on rx_data
//   rx_data      : incoming byte
//   rx_ready     : loader accepts a byte this cycle (low only while writing)
//   imem_we      : one-cycle write strobe per assembled word
//   imem_addr    : word address of the write (held afterwards)
//   imem_wdata   : assembled instruction word (held afterwards)
//   cpu_hold     : keeps the CPU in reset
//   load_done    : one-cycle pulse after a successful load
//   load_err     : sticky error flag, cleared by the next accepted header
module sm_imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int IW = ADDR_WIDTH + 1;   // index reaches 2^ADDR_WIDTH
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         len_q, len_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           word_q, word_d;     // first three bytes of a word
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic          xfer;
  logic          len_bad;
  logic          timeout;
  logic [IW-1:0] idx_inc;

  assign xfer    = rx_valid & ready_q;
  assign len_bad = (rx_data == 8'd0) || (32'(rx_data) > (32'd1 << ADDR_WIDTH));
  assign timeout = (idle_q == TW'(TIMEOUT - 1));
  assign idx_inc = idx_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      idle_q  <= idle_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer && rx_data == HDR) state_d = S_LEN;
      S_LEN:   if (xfer) state_d = len_bad ? S_IDLE : S_DATA;
               else if (timeout) state_d = S_IDLE;
      S_DATA:  if (xfer) begin
                 if (bcnt_q == 2'd3) state_d = S_WRITE;
               end else if (timeout) begin
                 state_d = S_IDLE;
               end
      S_WRITE: state_d = (idx_inc == len_q) ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    err_d   = err_q;
    done_d  = 1'b0;

    // Idle counter runs only while waiting for a byte inside a frame and
    // restarts on every transfer and every state change.
    if ((state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) &&
        !xfer && state_d == state_q)
      idle_d = idle_q + TW'(1);
    else
      idle_d = '0;

    case (state_q)
      S_IDLE: begin
        if (xfer && rx_data == HDR) begin
          hold_d = 1'b1;
          err_d  = 1'b0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            len_d  = IW'(rx_data);
            idx_d  = '0;
            bcnt_d = '0;
            csum_d = rx_data;
          end
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {rx_data, word_q[23:8]};
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            wdata_d = {rx_data, word_q};
          end
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      S_WRITE: idx_d = idx_inc;
      S_CSUM: begin
        if (xfer) begin
          if (rx_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    we_d    = (state_d == S_WRITE);
    ready_d = (state_d != S_WRITE);
  end

  assign rx_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Scoreboard bench for sm_imem_loader. A frame-level reference model parses
// each byte stream before it is driven and queues the expected memory writes
// and load outcomes; a negedge monitor pops and compares them as the DUT
// produces writes, load_done pulses and load_err rising edges.
module tb_sm_imem_loader;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  sm_imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_edge = 0;
  int t_hdr = 0;
  int t_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_ev[$];       // 1 = load_done, 0 = load_err
  bit            hold_exp = 1'b0;
  bit            err_exp  = 1'b0;
  logic [7:0]    fr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      err_prev = 1'b0;
    end else begin
      chk("rx_ready_vs_we", 32'(rx_ready), 32'(!imem_we));
      if (imem_we) begin
        chk("write_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) begin
          chk("imem_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
          chk("imem_wdata", imem_wdata, exp_data.pop_front());
        end
      end
      if (load_done) begin
        t_done = cyc;
        chk("done_expected", 32'(exp_ev.size() > 0), 32'd1);
        if (exp_ev.size() > 0) chk("outcome_done", 32'd1, 32'(exp_ev.pop_front()));
      end
      if (load_err && !err_prev) begin
        chk("err_expected", 32'(exp_ev.size() > 0), 32'd1);
        if (exp_ev.size() > 0) chk("outcome_err", 32'd0, 32'(exp_ev.pop_front()));
      end
      err_prev = load_err;
    end
  end

  // Reference model: parse the byte stream in fr at frame level.
  task automatic model();
    int k = 0;
    int n = fr.size();
    int L;
    int nw;
    logic [7:0] cs;
    while (k < n) begin
      if (fr[k] != 8'hA5) begin
        k++;
        continue;
      end
      k++;
      hold_exp = 1'b1;
      err_exp  = 1'b0;
      if (k >= n) begin exp_ev.push_back(1'b0); err_exp = 1'b1; break; end
      L = int'(fr[k]);
      k++;
      if (L == 0 || L > (1 << AW)) begin
        exp_ev.push_back(1'b0);
        err_exp = 1'b1;
        continue;
      end
      cs = 8'(L);
      nw = 0;
      while (nw < L && k + 4 <= n) begin
        exp_addr.push_back(AW'(nw));
        exp_data.push_back({fr[k+3], fr[k+2], fr[k+1], fr[k]});
        cs = cs ^ fr[k] ^ fr[k+1] ^ fr[k+2] ^ fr[k+3];
        k += 4;
        nw++;
      end
      if (nw < L || k >= n) begin   // stream stops mid-frame: timeout
        exp_ev.push_back(1'b0);
        err_exp = 1'b1;
        break;
      end
      if (fr[k] == cs) begin
        exp_ev.push_back(1'b1);
        hold_exp = 1'b0;
      end else begin
        exp_ev.push_back(1'b0);
        err_exp = 1'b1;
      end
      k++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 last_edge = cyc;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (n) @(posedge clk);
    end
  endtask

  task automatic send_stream(input int maxgap, input int gap_at, input int gap_len);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == gap_at) idle(gap_len);
      else if (maxgap > 0 && i > 0) idle(int'($urandom_range(0, maxgap)));
      send_byte(fr[i]);
      if (i == 0) t_hdr = last_edge;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic make_frame(input int L, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'(L));
    cs = 8'(L);
    for (int i = 0; i < 4 * L; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      cs ^= b;
    end
    fr.push_back(bad ? (cs ^ 8'h5C) : cs);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_addr.size() != 0 || exp_ev.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n == 400) chk("drain_timeout", 32'(exp_addr.size() + exp_ev.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("cpu_hold", 32'(cpu_hold), 32'(hold_exp));
    chk("load_err", 32'(load_err), 32'(err_exp));
  endtask

  task automatic run(input int maxgap, input int gap_at, input int gap_len);
    model();
    send_stream(maxgap, gap_at, gap_len);
    drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    chk({tag, "_load_done"},  32'(load_done),  32'd0);
    chk({tag, "_load_err"},   32'(load_err),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Reference 2-word program, rx_valid held high, checksum from the XOR rule
    fr = '{8'hA5, 8'h02, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    cs = 8'h00;
    for (int i = 1; i < fr.size(); i++) cs ^= fr[i];
    fr.push_back(cs);
    run(0, -1, 0);
    chk("frame_cycles", 32'(t_done - t_hdr), 32'(2 + 5 * 2));

    // Same frame with a bad checksum, then a good random frame
    fr[fr.size() - 1] = 8'hB7;
    run(0, -1, 0);
    make_frame(3, 1'b0);
    run(2, -1, 0);

    // Length errors
    fr = '{8'hA5, 8'h00};
    run(0, -1, 0);
    fr = '{8'hA5, 8'h41};
    run(0, -1, 0);
    make_frame(64, 1'b0);
    run(2, -1, 0);

    // Garbage while idle: nothing changes, then a valid load
    fr = '{8'h00, 8'hFF, 8'h5A};
    run(1, -1, 0);
    make_frame(2, 1'b0);
    run(1, -1, 0);

    // Timeout after one data byte, then a frame with a 15-cycle stall
    fr = '{8'hA5, 8'h01, 8'h13};
    run(0, -1, 0);
    make_frame(1, 1'b0);
    run(0, 3, TO - 1);

    // Random frames, some with corrupted checksums
    for (int f = 0; f < 8; f++) begin
      make_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
      run(int'($urandom_range(0, 3)), -1, 0);
    end

    // Reset in the middle of DATA
    fr = '{8'hA5, 8'h02, 8'h13, 8'h05};
    send_stream(0, -1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    hold_exp = 1'b0;
    err_exp  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    make_frame(4, 1'b0);
    run(1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
